// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// floor_request_scheduler
// Latches edge-detected call buttons and selects the next floor (SCAN policy).
// Revision: 1.0
// ============================================================================
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] buttons,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    floor_destiny,
  output logic                  dest_valid,
  output logic [1:0]            direction,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } dir_e;

  dir_e                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    dest_q, dest_d;
  logic                  valid_q, valid_d;
  logic [NUM_FLOORS-1:0] btn_q, btn_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr;
  logic                  cur_in_range;
  logic                  here;
  logic                  found_above;
  logic                  found_below;
  logic [FLOOR_W-1:0]    above_idx;
  logic [FLOOR_W-1:0]    below_idx;

  // Request bookkeeping plus nearest-request search on the registered pending bits
  always_comb begin
    cur_in_range = int'(current_floor) < NUM_FLOORS;
    press        = buttons & ~btn_q;
    btn_d        = buttons;
    clr          = '0;
    here         = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (cur_in_range && (current_floor == FLOOR_W'(i))) begin
        clr[i] = arrived;
        here   = pending_q[i];
      end
    end
    pending_d = (pending_q | press) & ~clr;

    found_above = 1'b0;
    above_idx   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(current_floor))) begin
        found_above = 1'b1;
        above_idx   = FLOOR_W'(i);
      end
    end

    found_below = 1'b0;
    below_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (i < int'(current_floor))) begin
        found_below = 1'b1;
        below_idx   = FLOOR_W'(i);
      end
    end
  end

  // A request at the current floor is always served first, in any state
  always_comb begin
    dir_d   = dir_q;
    dest_d  = dest_q;
    valid_d = 1'b0;
    case (dir_q)
      ST_IDLE: begin
        if (here) begin
          dest_d  = current_floor;
          valid_d = 1'b1;
        end else if (found_above) begin
          dir_d   = ST_UP;
          dest_d  = above_idx;
          valid_d = 1'b1;
        end else if (found_below) begin
          dir_d   = ST_DOWN;
          dest_d  = below_idx;
          valid_d = 1'b1;
        end
      end
      ST_UP: begin
        if (here) begin
          dest_d  = current_floor;
          valid_d = 1'b1;
        end else if (found_above) begin
          dest_d  = above_idx;
          valid_d = 1'b1;
        end else if (found_below) begin
          dir_d   = ST_DOWN;
          dest_d  = below_idx;
          valid_d = 1'b1;
        end else begin
          dir_d = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (here) begin
          dest_d  = current_floor;
          valid_d = 1'b1;
        end else if (found_below) begin
          dest_d  = below_idx;
          valid_d = 1'b1;
        end else if (found_above) begin
          dir_d   = ST_UP;
          dest_d  = above_idx;
          valid_d = 1'b1;
        end else begin
          dir_d = ST_IDLE;
        end
      end
      default: begin
        dir_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= buttons;
      pending_q <= '0;
      dir_q     <= ST_IDLE;
      dest_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      btn_q     <= btn_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      dest_q    <= dest_d;
      valid_q   <= valid_d;
    end
  end

  assign floor_destiny = dest_q;
  assign dest_valid    = valid_q;
  assign direction     = dir_q;
  assign pending       = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// tb_floor_request_scheduler
// Scoreboard bench: three scheduler sizes against a floor-list reference model.
// Revision: 1.0
// ============================================================================
module tb_floor_request_scheduler;

  typedef struct packed {
    logic [7:0] pend;
    logic [1:0] dir;
    logic [2:0] dest;
    logic       valid;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0][7:0] btn_in;
  logic [2:0][2:0] cur_in;
  logic [2:0]      arr_in;

  always #5 clk = ~clk;

  logic [3:0] pend0; logic [1:0] dir0; logic [1:0] dest0; logic val0;
  logic [7:0] pend1; logic [1:0] dir1; logic [2:0] dest1; logic val1;
  logic [4:0] pend2; logic [1:0] dir2; logic [2:0] dest2; logic val2;

  floor_request_scheduler #(.NUM_FLOORS(4), .FLOOR_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .buttons(btn_in[0][3:0]), .current_floor(cur_in[0][1:0]),
    .arrived(arr_in[0]), .floor_destiny(dest0), .dest_valid(val0),
    .direction(dir0), .pending(pend0));

  floor_request_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .buttons(btn_in[1]), .current_floor(cur_in[1]),
    .arrived(arr_in[1]), .floor_destiny(dest1), .dest_valid(val1),
    .direction(dir1), .pending(pend1));

  floor_request_scheduler #(.NUM_FLOORS(5), .FLOOR_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .buttons(btn_in[2][4:0]), .current_floor(cur_in[2]),
    .arrived(arr_in[2]), .floor_destiny(dest2), .dest_valid(val2),
    .direction(dir2), .pending(pend2));

  int checks   = 0;
  int failures = 0;
  trio_t sb[$];

  // Reference model state: pending floors, last button levels, scheduler outputs
  logic [7:0] m_pend [3];
  logic [7:0] m_btn  [3];
  int         m_dir  [3];
  int         m_dest [3];
  bit         m_valid[3];

  function automatic int nf(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 8 : 5);
  endfunction

  function automatic int cur_of(input int k);
    return (k == 0) ? int'(cur_in[0][1:0]) : int'(cur_in[k]);
  endfunction

  function automatic obs_t actual(input int k);
    obs_t o;
    case (k)
      0:       o = '{pend: {4'b0, pend0}, dir: dir0, dest: {1'b0, dest0}, valid: val0};
      1:       o = '{pend: pend1, dir: dir1, dest: dest1, valid: val1};
      default: o = '{pend: {3'b0, pend2}, dir: dir2, dest: dest2, valid: val2};
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int   n, cur, above, below, nd, ndest;
    bit   here, nv;
    logic [7:0] np;
    n   = nf(k);
    cur = cur_of(k);
    if (rst) begin
      m_pend[k] = '0; m_dir[k] = 0; m_dest[k] = 0; m_valid[k] = 0;
      m_btn[k]  = btn_in[k];
      return;
    end
    above = -1;
    below = -1;
    for (int f = 0; f < n; f++) begin
      if (m_pend[k][f]) begin
        if (f > cur && (above < 0 || f - cur < above - cur)) above = f;
        if (f < cur && (below < 0 || cur - f < cur - below)) below = f;
      end
    end
    here  = (cur < n) && m_pend[k][cur];
    nv    = 1;
    nd    = m_dir[k];
    ndest = m_dest[k];
    if (m_dir[k] == 0) begin
      if (here) ndest = cur;
      else if (above >= 0) begin nd = 1; ndest = above; end
      else if (below >= 0) begin nd = 2; ndest = below; end
      else nv = 0;
    end else if (m_dir[k] == 1) begin
      if (here) ndest = cur;
      else if (above >= 0) ndest = above;
      else if (below >= 0) begin nd = 2; ndest = below; end
      else begin nd = 0; nv = 0; end
    end else begin
      if (here) ndest = cur;
      else if (below >= 0) ndest = below;
      else if (above >= 0) begin nd = 1; ndest = above; end
      else begin nd = 0; nv = 0; end
    end
    np = m_pend[k];
    for (int f = 0; f < n; f++) begin
      if (btn_in[k][f] && !m_btn[k][f]) np[f] = 1'b1;
      if (arr_in[k] && cur == f)        np[f] = 1'b0;
    end
    m_pend[k] = np; m_dir[k] = nd; m_dest[k] = ndest; m_valid[k] = nv;
    m_btn[k]  = btn_in[k];
  endtask

  // Apply current inputs for one clock, pushing the expected post-edge outputs
  task automatic tick();
    trio_t e;
    for (int k = 0; k < 3; k++) begin
      model_step(k);
      e[k] = '{pend: m_pend[k], dir: 2'(m_dir[k]), dest: 3'(m_dest[k]), valid: m_valid[k]};
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : monitor
    trio_t e;
    obs_t  a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          a = actual(k);
          chk($sformatf("inst%0d_pending", k), int'(a.pend), int'(e[k].pend));
          chk($sformatf("inst%0d_direction", k), int'(a.dir), int'(e[k].dir));
          chk($sformatf("inst%0d_floor_destiny", k), int'(a.dest), int'(e[k].dest));
          chk($sformatf("inst%0d_dest_valid", k), int'(a.valid), int'(e[k].valid));
        end
      end
    end
  end

  initial begin : stimulus
    int mx;
    rst    = 1'b1;
    btn_in = '0;
    cur_in = '0;
    arr_in = '0;
    @(negedge clk);
    ticks(2);
    chk("reset_pending", int'(pend0), 0);
    chk("reset_valid", int'(val0), 0);
    chk("reset_direction", int'(dir0), 0);

    // single press above the car
    rst = 1'b0; cur_in[0] = 3'd0; btn_in[0] = 8'h04; tick();
    chk("t1_pending", int'(pend0), 4);
    btn_in[0] = 8'h00; tick();
    chk("t1_dest", int'(dest0), 2);
    chk("t1_valid", int'(val0), 1);
    chk("t1_dir", int'(dir0), 1);

    // sweep up, reverse, go idle
    rst = 1'b1; tick(); rst = 1'b0;
    btn_in[0] = 8'h0A; tick();
    btn_in[0] = 8'h00; tick();
    cur_in[0] = 3'd2; tick();
    chk("t2_dest_up", int'(dest0), 3);
    cur_in[0] = 3'd3; arr_in[0] = 1'b1; tick(); arr_in[0] = 1'b0;
    chk("t2_pending_after3", int'(pend0), 2);
    tick();
    chk("t2_dir_down", int'(dir0), 2);
    chk("t2_dest_down", int'(dest0), 1);
    cur_in[0] = 3'd1; arr_in[0] = 1'b1; tick(); arr_in[0] = 1'b0;
    chk("t2_pending_empty", int'(pend0), 0);
    tick();
    chk("t2_dir_idle", int'(dir0), 0);
    chk("t2_valid_idle", int'(val0), 0);
    chk("t2_dest_hold", int'(dest0), 1);

    // held button served once
    rst = 1'b1; tick(); rst = 1'b0;
    cur_in[0] = 3'd1; btn_in[0] = 8'h02; ticks(3);
    arr_in[0] = 1'b1; tick(); arr_in[0] = 1'b0;
    ticks(6);
    chk("t3_held_cleared", int'(pend0[1]), 0);
    btn_in[0] = 8'h00; tick();

    // press and arrival at the same floor
    rst = 1'b1; tick(); rst = 1'b0;
    cur_in[0] = 3'd3; btn_in[0] = 8'h08; arr_in[0] = 1'b1; tick(); arr_in[0] = 1'b0;
    chk("t4_pending3", int'(pend0[3]), 0);
    tick();
    chk("t4_no_dest", int'(val0), 0);
    btn_in[0] = 8'h00;

    // buttons held through reset, then reset mid-travel
    btn_in[0] = 8'h06; rst = 1'b1; ticks(3); rst = 1'b0; ticks(2);
    chk("t5_pending", int'(pend0), 0);
    chk("t5_valid", int'(val0), 0);
    btn_in[0] = 8'h00; cur_in[0] = 3'd0; tick();
    btn_in[0] = 8'h08; tick(); btn_in[0] = 8'h00; tick();
    chk("t5_dir_up", int'(dir0), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_dir", int'(dir0), 0);
    chk("t5_rst_valid", int'(val0), 0);
    chk("t5_rst_dest", int'(dest0), 0);
    chk("t5_rst_pending", int'(pend0), 0);

    // request at current floor first, then continue up
    cur_in[0] = 3'd1; btn_in[0] = 8'h0A; tick(); btn_in[0] = 8'h00; tick();
    chk("t6_dest_here", int'(dest0), 1);
    chk("t6_dir_idle", int'(dir0), 0);
    arr_in[0] = 1'b1; tick(); arr_in[0] = 1'b0; tick();
    chk("t6_dir_up", int'(dir0), 1);
    chk("t6_dest_up", int'(dest0), 3);

    // eight floors, travelling down with requests at both ends
    rst = 1'b1; tick(); rst = 1'b0;
    cur_in[1] = 3'd5; btn_in[1] = 8'h01; tick();
    btn_in[1] = 8'h81; ticks(2);
    chk("t6b_dir", int'(dir1), 2);
    chk("t6b_dest", int'(dest1), 0);
    chk("t6b_pending", int'(pend1), 8'h81);

    // five floors, car index beyond the top: arrival ignored
    cur_in[2] = 3'd7; btn_in[2] = 8'h10; tick(); btn_in[2] = 8'h00; tick();
    arr_in[2] = 1'b1; tick(); arr_in[2] = 1'b0;
    chk("oor_pending", int'(pend2), 16);
    chk("oor_dir", int'(dir2), 2);
    chk("oor_dest", int'(dest2), 4);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 3; k++) begin
        mx = (k == 0) ? 3 : 7;
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 9) == 0) btn_in[k][b] = ~btn_in[k][b];
        if ($urandom_range(0, 9) == 0)
          cur_in[k] = 3'($urandom_range(0, mx));
        else if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1 && int'(cur_in[k]) < mx) cur_in[k] = cur_in[k] + 3'd1;
          else if (cur_in[k] > 3'd0) cur_in[k] = cur_in[k] - 3'd1;
        end
        arr_in[k] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    rst = 1'b0; arr_in = '0;
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
Parametrised successor to the one-hot button-to-floor encoder. It latches edge-detected call buttons for NUM_FLOORS floors into a pending-request register. It then selects the next destination floor with a SCAN (keep-direction) policy, and clears each request when the car reports arrival. It sits between the call-button inputs and the car motion controller, driving floor_destiny.

Parameters:
NUM_FLOORS, 4, number of floors/buttons; legal range 2 to 2**FLOOR_W
FLOOR_W, 2, width of floor index; must be >= clog2(NUM_FLOORS)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
buttons  input  NUM_FLOORS  call buttons, level, bit i = floor i
current_floor  input  FLOOR_W  floor the car is at or passing
arrived  input  1  one-cycle pulse: car stopped at current_floor
floor_destiny  output  FLOOR_W  registered selected destination floor
dest_valid  output  1  registered; floor_destiny is a live target
direction  output  2  registered scheduler state: 00 IDLE, 01 UP, 10 DOWN
pending  output  NUM_FLOORS  registered outstanding requests

Behaviour:
- Reset (rst=1 at clock edge): pending=0, direction=IDLE, floor_destiny=0, dest_valid=0, btn_q<=buttons. Buttons held through reset are not counted as presses after reset.
- Edge detect: press_i = buttons[i] & ~btn_q[i]. btn_q<=buttons every non-reset cycle. A held button produces exactly one request.
- Clear: clr_i = arrived & (current_floor==i) & (current_floor<NUM_FLOORS).
- Pending update: pending[i] <= (pending[i] | press_i) & ~clr_i. Clear wins on a simultaneous press and arrival at the same floor, because that press counts as served.
- current_floor >= NUM_FLOORS: arrived is ignored. Selection treats no floor as "at current". Above/below comparisons still use the numeric value.
- Selection uses the registered pending bits, so it does not see a press or clear from the same cycle.
- Latency: button edge at cycle n -> pending bit at n+1 -> floor_destiny/dest_valid/direction at n+2.
- The scheduler FSM is held in direction. Next state and outputs are registered every cycle.
- IDLE:
  - pending at current_floor -> dest=current_floor, valid=1, stay IDLE.
  - else any pending above -> UP, dest=nearest above.
  - else any below -> DOWN, dest=nearest below.
  - else valid=0.
- UP:
  - any pending >= current_floor -> stay UP, dest=nearest such (lowest index >= current).
  - else any pending below -> DOWN, dest=nearest below (highest index < current).
  - else -> IDLE, valid=0.
- DOWN:
  - mirror of UP: any pending <= current_floor -> stay DOWN, dest=nearest (highest index <= current).
  - else any above -> UP, dest=nearest above.
  - else -> IDLE, valid=0.
- New requests arriving mid-travel are picked up on the next selection. A closer request in the current direction retargets floor_destiny, and this is intended.
- When dest_valid=0, floor_destiny holds its last value.
- Reset mid-travel: everything returns to reset values in one cycle. Requests are lost, and currently held buttons are not re-requested.
- No wrap-around: floors are linear. Index 0 is the bottom and NUM_FLOORS-1 is the top.

Test Plan:
1. Reset, current_floor=0, pulse buttons[2] 1 cycle -> pending=4'b0100 after 1 clk; after 2 clk floor_destiny=2, dest_valid=1, direction=01.
2. pending=4'b1010, direction=UP, current_floor=2 -> floor_destiny=3. Then current_floor=3 + arrived -> pending=4'b0010 next clk, then direction=10, floor_destiny=1. Arrived at 1 -> pending=0, direction=00, dest_valid=0, floor_destiny stays 1.
3. Hold buttons[1] for 10 cycles, current_floor=1, arrived pulse at cycle 4 -> pending[1] cleared and stays 0 for remaining held cycles.
4. Rising edge on buttons[3] in same cycle as arrived with current_floor=3 -> pending[3] stays 0; no destination issued.
5. Hold buttons=4'b0110 while rst=1 for 3 cycles, release rst -> pending stays 0, dest_valid=0 until a new edge. Repeat with rst asserted while direction=UP -> all outputs at reset values next clk.
6. IDLE, current_floor=1, press buttons[1] and buttons[3] together -> floor_destiny=1, direction=00. After arrived at 1 -> direction=01, floor_destiny=3. Also NUM_FLOORS=8, FLOOR_W=3: current_floor=5, pending 0 and 7, DOWN -> floor_destiny=0.
